// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer: per-channel sync + stability filter giving clean level, edge pulses and long-press/repeat pulses
module multi_channel_debouncer #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 10_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int ACTIVE_LOW    = 1,
  parameter int CNT_W         = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] inp,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] hold,
  output logic            any_rise
);
  localparam logic POL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] REP_M1 = CNT_W'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_t;
  logic [N_CH-1:0] rise_nxt;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sr;
    logic s, last, lvl, r, f, h, take, rn, fn, hn;
    logic [CNT_W-1:0] scnt, scnt_nxt, hcnt, hcnt_nxt;
    state_t st, st_nxt;
    assign s = sr[SYNC_STAGES-1] ^ POL;
    always_comb begin
      scnt_nxt = (s != last) ? '0 : (scnt == STABLE) ? scnt : scnt + CNT_W'(1);
      take = (scnt_nxt == STABLE) && (last != lvl);
      rn = take && last;
      fn = take && !last;
    end
    // A rise takes priority over the level==0 return to IDLE, since level is still 0 in the rise cycle.
    always_comb begin
      st_nxt = st;
      hcnt_nxt = hcnt + CNT_W'(1);
      hn = 1'b0;
      if (HOLD_CYCLES == 0 || fn || (!lvl && !rn)) begin
        st_nxt = IDLE;
        hcnt_nxt = '0;
      end else if (st == IDLE) begin
        st_nxt = rn ? WAIT_HOLD : IDLE;
        hcnt_nxt = '0;
      end else if (st == WAIT_HOLD && hcnt == HOLD_M1) begin
        st_nxt = REPEAT;
        hcnt_nxt = '0;
        hn = 1'b1;
      end else if (st == REPEAT && REPEAT_CYCLES == 0) begin
        hcnt_nxt = hcnt;
      end else if (st == REPEAT && hcnt == REP_M1) begin
        hcnt_nxt = '0;
        hn = 1'b1;
      end
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr <= {SYNC_STAGES{POL}};
        last <= 1'b0;
        scnt <= '0;
        hcnt <= '0;
        st <= IDLE;
        lvl <= 1'b0;
        r <= 1'b0;
        f <= 1'b0;
        h <= 1'b0;
      end else begin
        sr <= {sr[SYNC_STAGES-2:0], inp[c]};
        last <= s;
        scnt <= scnt_nxt;
        hcnt <= hcnt_nxt;
        st <= st_nxt;
        lvl <= take ? last : lvl;
        r <= rn;
        f <= fn;
        h <= hn;
      end
    end
    assign rise_nxt[c] = rn;
    assign level[c] = lvl;
    assign rise[c] = r;
    assign fall[c] = f;
    assign hold[c] = h;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_rise <= 1'b0;
    else any_rise <= |rise_nxt;
  end
endmodule

// File: tb/tb_multi_channel_debouncer.sv
// tb_multi_channel_debouncer: randomized scenarios against a window/arithmetic reference model
module tb_multi_channel_debouncer;
  localparam int ST = 8, HC = 20, RC = 5;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] inp = 4'hf;
  logic [3:0] level, rise, fall, hold, level2, rise2, fall2, hold2;
  logic any_rise, any_rise2;
  logic [3:0] hist [8192];
  logic [3:0] m_lvl = '0, m_rise = '0, m_fall = '0, m_hold = '0;
  int r_at [4];
  int t = 0, errors = 0, checks = 0;
  logic [33:0] got, exp_v;

  multi_channel_debouncer #(.N_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(ST), .HOLD_CYCLES(HC),
    .REPEAT_CYCLES(RC), .ACTIVE_LOW(1), .CNT_W(26)) dut (
    .clk(clk), .rst(rst), .inp(inp), .level(level), .rise(rise), .fall(fall), .hold(hold), .any_rise(any_rise));
  multi_channel_debouncer #(.N_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(ST), .HOLD_CYCLES(0),
    .REPEAT_CYCLES(RC), .ACTIVE_LOW(1), .CNT_W(26)) dut2 (
    .clk(clk), .rst(rst), .inp(inp), .level(level2), .rise(rise2), .fall(fall2), .hold(hold2), .any_rise(any_rise2));

  assign got = {level, rise, fall, hold, any_rise, level2, rise2, fall2, hold2, any_rise2};
  assign exp_v = {m_lvl, m_rise, m_fall, m_hold, |m_rise, m_lvl, m_rise, m_fall, 4'b0, |m_rise};

  always #5 clk = ~clk;

  // Active-high sample history; the debounced input seen at edge k is the raw value sampled two edges earlier.
  function automatic logic sv(int k, int c);
    return (k <= 0) ? 1'b0 : hist[k % 8192][c];
  endfunction

  task automatic step(input logic [3:0] v);
    logic s0, stable;
    inp = v;
    @(posedge clk);
    t++;
    hist[t % 8192] = ~v;
    for (int c = 0; c < 4; c++) begin
      s0 = sv(t - 2, c);
      stable = 1'b1;
      for (int j = 1; j <= ST; j++) if (sv(t - 2 - j, c) != s0) stable = 1'b0;
      m_rise[c] = stable && s0 && !m_lvl[c];
      m_fall[c] = stable && !s0 && m_lvl[c];
      if (m_rise[c] || m_fall[c]) m_lvl[c] = s0;
      if (m_rise[c]) r_at[c] = t;
      m_hold[c] = m_lvl[c] && !m_rise[c] && (t - r_at[c] >= HC) && ((t - r_at[c] - HC) % RC == 0);
    end
    #1;
  endtask

  task automatic clear_model();
    t = 0;
    m_lvl = '0; m_rise = '0; m_fall = '0; m_hold = '0;
    for (int c = 0; c < 4; c++) r_at[c] = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (got !== 34'd0) begin errors++; $display("FAIL reset_initial got=%h exp=0", got); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got !== 34'd0) begin errors++; $display("FAIL reset_clocked got=%h exp=0", got); end
    clear_model();
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_idle t=%0d got=%h exp=%h", t, got, exp_v); end
    end
  endtask

  task automatic test_clean();
    int t0, t1;
    t0 = t;
    for (int i = 0; i < 41; i++) begin
      step(4'he);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL clean t=%0d got=%h exp=%h", t, got, exp_v); end
      if (t == t0 + 11) begin
        checks++;
        if ({level[0], rise[0], any_rise} !== 3'b111) begin
          errors++; $display("FAIL clean_latency got=%b exp=111", {level[0], rise[0], any_rise});
        end
      end
    end
    t1 = t;
    for (int i = 0; i < 25; i++) begin
      step(4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL clean_release t=%0d got=%h exp=%h", t, got, exp_v); end
      if (t == t1 + 11) begin
        checks++;
        if ({level[0], fall[0]} !== 2'b01) begin errors++; $display("FAIL clean_fall got=%b exp=01", {level[0], fall[0]}); end
      end
    end
  endtask

  task automatic test_bounce();
    logic b;
    int n, seg, tl;
    b = 1'b1;
    n = 0;
    while (n < 30 || !b) begin
      seg = $urandom_range(1, 7);
      b = ~b;
      for (int i = 0; i < seg; i++) begin
        step({2'b11, b, 1'b1});
        n++;
        checks++;
        if (got !== exp_v || level[1] !== 1'b0) begin
          errors++; $display("FAIL bounce t=%0d got=%h exp=%h", t, got, exp_v);
        end
      end
    end
    tl = t + 1;
    for (int i = 0; i < 20; i++) begin
      step(4'hd);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL bounce_settle t=%0d got=%h exp=%h", t, got, exp_v); end
      if (t == tl + 10) begin
        checks++;
        if (rise[1] !== 1'b1) begin errors++; $display("FAIL bounce_rise got=%b exp=1", rise[1]); end
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL bounce_release t=%0d got=%h exp=%h", t, got, exp_v); end
    end
  endtask

  task automatic test_long_press();
    int t0, tr, nh, late;
    t0 = t;
    nh = 0;
    late = 0;
    for (int i = 0; i < 71; i++) begin
      step(4'hb);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL long t=%0d got=%h exp=%h", t, got, exp_v); end
      if (t > t0 + 11 && hold[2]) nh++;
    end
    checks++;
    if (nh != 9) begin errors++; $display("FAIL long_hold_count got=%0d exp=9", nh); end
    tr = t;
    for (int i = 0; i < 25; i++) begin
      step(4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL long_release t=%0d got=%h exp=%h", t, got, exp_v); end
      if (t >= tr + 11 && hold[2]) late++;
      if (t == tr + 11) begin
        checks++;
        if (fall[2] !== 1'b1) begin errors++; $display("FAIL long_fall got=%b exp=1", fall[2]); end
      end
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL long_hold_after_fall got=%0d exp=0", late); end
  endtask

  task automatic test_glitch();
    int np, len, nr, nf;
    np = 0;
    for (int i = 0; i < 27; i++) begin
      step(i < 7 ? 4'h7 : 4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL glitch t=%0d got=%h exp=%h", t, got, exp_v); end
      if (level[3] | rise[3] | fall[3] | hold[3]) np++;
    end
    checks++;
    if (np != 0) begin errors++; $display("FAIL glitch_reject got=%0d exp=0", np); end
    len = $urandom_range(9, 12);
    nr = 0;
    nf = 0;
    for (int i = 0; i < len + 20; i++) begin
      step(i < len ? 4'h7 : 4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL glitch_accept t=%0d got=%h exp=%h", t, got, exp_v); end
      if (rise[3]) nr++;
      if (fall[3]) nf++;
    end
    checks++;
    if (nr != 1 || nf != 1) begin errors++; $display("FAIL glitch_pulses rise=%0d fall=%0d exp=1,1", nr, nf); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 38; i++) begin
      step(4'hb);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL rmid_pre t=%0d got=%h exp=%h", t, got, exp_v); end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (got !== 34'd0) begin errors++; $display("FAIL rmid_async got=%h exp=0", got); end
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step(4'hb);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL rmid_post t=%0d got=%h exp=%h", t, got, exp_v); end
      if (t == 11 || t == 31) begin
        checks++;
        if ((t == 11 ? rise[2] : hold[2]) !== 1'b1) begin errors++; $display("FAIL rmid_restart t=%0d got=0 exp=1", t); end
      end
    end
    for (int i = 0; i < 25; i++) begin
      step(4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL rmid_release t=%0d got=%h exp=%h", t, got, exp_v); end
    end
  endtask

  task automatic test_simultaneous();
    int t0, na;
    t0 = t;
    na = 0;
    for (int i = 0; i < 35; i++) begin
      step(4'h6);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL simul t=%0d got=%h exp=%h", t, got, exp_v); end
      if (any_rise) na++;
      if (t == t0 + 11) begin
        checks++;
        if ({rise[0], rise[3], any_rise} !== 3'b111) begin
          errors++; $display("FAIL simul_rise got=%b exp=111", {rise[0], rise[3], any_rise});
        end
      end
    end
    checks++;
    if (na != 1) begin errors++; $display("FAIL simul_any_rise_count got=%0d exp=1", na); end
    for (int i = 0; i < 25; i++) begin
      step(4'hf);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL simul_release t=%0d got=%h exp=%h", t, got, exp_v); end
    end
  endtask

  task automatic test_random();
    int rem [4];
    logic [3:0] v;
    v = 4'hf;
    for (int c = 0; c < 4; c++) rem[c] = $urandom_range(1, 20);
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          v[c] = ~v[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(9, 45);
        end else rem[c]--;
      end
      step(v);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL random t=%0d got=%h exp=%h", t, got, exp_v); end
      checks++;
      if (((rise & fall) | (rise & hold) | (fall & hold)) !== 4'b0) begin
        errors++; $display("FAIL random_exclusive t=%0d rise=%b fall=%b hold=%b exp=disjoint", t, rise, fall, hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_long_press();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
